// File: rtl/aluop_pkg.sv
// Shared types and constants for the ALU operand-entry stage.
// State encodings double as the status-LED pattern.
package aluop_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    READY    = 2'b11
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_LAST = OP_DEC;

  function automatic logic is_bad_op(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/aluop_loader_button_debounce.sv
// Two-flop synchronizer, stability-count debouncer and registered rising-edge
// pulse for a raw push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_prev_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      rise_q    <= db_q & ~db_prev_q;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LIMIT) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = db_q;
  assign rise  = rise_q;

endmodule

// File: rtl/aluop_loader.sv
// Steps the slide switches into operand A, operand B and opcode on debounced
// button presses, and presents them as a registered set to the ALU stage.
module aluop_loader
  import aluop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn,
  output logic [7:0] opa,
  output logic [7:0] opb,
  output logic [3:0] opcode,
  output logic       valid,
  output logic       start,
  output logic       bad_op,
  output logic [1:0] stage
);

  logic db_level, db_rise, press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn),
    .level(db_level),
    .rise (db_rise)
  );

  // The rise pulse always coincides with a high level; the AND keeps it honest.
  assign press = db_rise & db_level;

  state_e     state_q;
  logic [7:0] opa_q, opb_q;
  logic [3:0] opcode_q;
  logic       valid_q, start_q, bad_op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTER_A;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      bad_op_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (press) begin
        unique case (state_q)
          ENTER_A: begin
            opa_q   <= sw;
            state_q <= ENTER_B;
          end
          ENTER_B: begin
            opb_q   <= sw;
            state_q <= ENTER_OP;
          end
          ENTER_OP: begin
            opcode_q <= sw[3:0];
            state_q  <= READY;
            valid_q  <= 1'b1;
            start_q  <= 1'b1;
            bad_op_q <= is_bad_op(sw[3:0]);
          end
          READY: begin
            state_q  <= ENTER_A;
            valid_q  <= 1'b0;
            bad_op_q <= 1'b0;
          end
          default: state_q <= ENTER_A;
        endcase
      end
    end
  end

  assign opa    = opa_q;
  assign opb    = opb_q;
  assign opcode = opcode_q;
  assign valid  = valid_q;
  assign start  = start_q;
  assign bad_op = bad_op_q;
  assign stage  = state_q;

endmodule

// File: tb/tb_aluop_loader.sv
// Directed bench for aluop_loader with a short debounce window of 4 cycles.
module tb_aluop_loader;

  logic       clk = 1'b0;
  logic       rst, btn;
  logic [7:0] sw;
  logic [7:0] opa, opb;
  logic [3:0] opcode;
  logic       valid, start, bad_op;
  logic [1:0] stage;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aluop_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .btn   (btn),
    .opa   (opa),
    .opb   (opb),
    .opcode(opcode),
    .valid (valid),
    .start (start),
    .bad_op(bad_op),
    .stage (stage)
  );

  typedef struct {
    logic [7:0] sw;
    logic [7:0] opa, opb;
    logic [3:0] opcode;
    logic       valid, start, bad_op;
    logic [1:0] stage;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_opa, input logic [7:0] e_opb,
                         input logic [3:0] e_opc, input logic e_v, input logic e_s,
                         input logic e_b, input logic [1:0] e_stage);
    chk({tag, ".opa"}, opa, e_opa);
    chk({tag, ".opb"}, opb, e_opb);
    chk({tag, ".opcode"}, {4'h0, opcode}, {4'h0, e_opc});
    chk({tag, ".valid"}, {7'h0, valid}, {7'h0, e_v});
    chk({tag, ".start"}, {7'h0, start}, {7'h0, e_s});
    chk({tag, ".bad_op"}, {7'h0, bad_op}, {7'h0, e_b});
    chk({tag, ".stage"}, {6'h0, stage}, {6'h0, e_stage});
  endtask

  // btn rises at a negedge; sync (2) + debounce (4) + edge reg (1) puts the
  // press in the 7th cycle, so outputs are updated by the 8th negedge.
  task automatic press_hold(input logic [7:0] s);
    sw  = s;
    btn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int          start_seen;
  logic [1:0]  hold_stage;
  int          bp[6];

  initial begin
    tv[0] = '{8'h22, 8'h22, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b01};
    tv[1] = '{8'h11, 8'h22, 8'h11, 4'h0, 1'b0, 1'b0, 1'b0, 2'b10};
    tv[2] = '{8'h00, 8'h22, 8'h11, 4'h0, 1'b1, 1'b1, 1'b0, 2'b11};
    tv[3] = '{8'hAA, 8'h22, 8'h11, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00};
    tv[4] = '{8'h44, 8'h44, 8'h11, 4'h0, 1'b0, 1'b0, 1'b0, 2'b01};
    tv[5] = '{8'h55, 8'h44, 8'h55, 4'h0, 1'b0, 1'b0, 1'b0, 2'b10};
    tv[6] = '{8'hF9, 8'h44, 8'h55, 4'h9, 1'b1, 1'b1, 1'b1, 2'b11};
    tv[7] = '{8'h12, 8'h44, 8'h55, 4'h9, 1'b0, 1'b0, 1'b0, 2'b00};

    rst = 1'b1;
    btn = 1'b0;
    sw  = 8'h00;
    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);

    rst = 1'b0;
    start_seen = 0;
    sw = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start) start_seen++;
    end
    chk("idle.start_count", 8'(start_seen), 8'd0);
    chk_all("idle", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 8; i++) begin
      press_hold(tv[i].sw);
      chk_all($sformatf("vec%0d", i), tv[i].opa, tv[i].opb, tv[i].opcode,
              tv[i].valid, tv[i].start, tv[i].bad_op, tv[i].stage);
      @(negedge clk);
      chk($sformatf("vec%0d.start_next", i), {7'h0, start}, 8'h00);
      chk($sformatf("vec%0d.valid_next", i), {7'h0, valid}, {7'h0, tv[i].valid});
      release_btn();
      chk($sformatf("vec%0d.stage_rel", i), {6'h0, stage}, {6'h0, tv[i].stage});
    end

    // Bouncy press: high/low runs never reach 4 stable cycles, then hold high.
    bp = '{1, 2, 3, 1, 2, 1};
    sw = 8'h77;
    for (int k = 0; k < 6; k++) begin
      btn = (k % 2 == 0);
      repeat (bp[k]) @(negedge clk);
    end
    btn = 1'b1;
    repeat (7) @(negedge clk);
    chk("bounce.stage_before", {6'h0, stage}, 8'h00);
    @(negedge clk);
    chk("bounce.stage_after", {6'h0, stage}, 8'h01);
    chk("bounce.opa", opa, 8'h77);
    hold_stage = stage;
    repeat (20) @(negedge clk);
    chk("bounce.held_one_event", {6'h0, stage}, 8'h01);
    release_btn();

    // sw wiggles around the press; only the press-cycle value is captured.
    sw  = 8'h55;
    btn = 1'b1;
    repeat (7) @(negedge clk);
    sw = 8'h33;
    @(negedge clk);
    sw = 8'h55;
    chk("swtime.opb", opb, 8'h33);
    chk("swtime.stage", {6'h0, stage}, 8'h02);
    repeat (5) @(negedge clk);
    chk("swtime.opb_hold", opb, 8'h33);
    release_btn();

    // Reset in ENTER_OP while a press is being debounced.
    btn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all("rst_mid", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (12) @(negedge clk);
    chk("rst_hold.stage", {6'h0, stage}, 8'h00);
    chk("rst_hold.start", {7'h0, start}, 8'h00);
    btn = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk_all("post_rst", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aluop_loader.md
# aluop_loader

Operand-entry stage feeding the board ALU. It debounces a single step push-button and uses it to walk the 8 slide switches through three entries: operand A, operand B, then opcode. It presents the captured values to the downstream ALU stage as stable registered buses with a valid level and a one-cycle start pulse. State is shown on two status LEDs so the user knows which entry comes next.

## Interface
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles before a button level change is accepted (10 ms at 50 MHz); legal range 2..2^24-1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  8  raw slide switches, quasi-static, sampled only on a press event.
- btn  in  1  raw step push-button, asynchronous, active-high, bouncy.
- opa  out  8  captured operand A.
- opb  out  8  captured operand B.
- opcode  out  4  captured opcode, from sw[3:0].
- valid  out  1  high while opa/opb/opcode form a complete, committed set.
- start  out  1  one-cycle pulse on entry to READY.
- bad_op  out  1  high in READY when opcode > 8 (ALU yields 0 for these).
- stage  out  2  current state encoding for the status LEDs.

## Operation
- Synchronizer: btn passes through 2 flops to give btn_s, with reset value 0.
- Debounce: db is the accepted level and cnt the stability counter.
  - If btn_s == db, cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and btn_s != db, then db <= btn_s and cnt <= 0.
  - Any glitch back to db before the limit restarts the count.
- Press event: a registered one-cycle pulse on each 0->1 transition of db. Releases generate no event.
- FSM, stage encoding in brackets. Every transition happens only on a press event.
  - ENTER_A [00]: opa <= sw; go to ENTER_B.
  - ENTER_B [01]: opb <= sw; go to ENTER_OP.
  - ENTER_OP [10]: opcode <= sw[3:0]; go to READY; start=1 for the following cycle.
  - READY [11]: valid=0; go to ENTER_A. opa, opb and opcode are retained until overwritten.
- valid = (state == READY).
- bad_op = (state == READY) && (opcode > 4'd8).
- sw[7:4] is ignored in ENTER_OP.
- No arithmetic is done here; all buses pass through at their native width.

## Timing
- Reset values: state=ENTER_A, opa=0, opb=0, opcode=0, valid=0, start=0, bad_op=0, stage=00, db=0, cnt=0, synchronizer flops=0.
- Reset wins over a simultaneous press. A press that is mid-debounce when reset arrives is discarded.
- Latency from a clean btn rise (held stable) to the press pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-register cycle.
- The FSM acts on the press cycle. Outputs (captured bus, state, valid, start) change at the next edge, i.e. one cycle after the press pulse.
- sw is sampled in the press cycle itself. Switch motion outside that cycle has no effect.
- start is high for exactly one cycle, in the first cycle of READY.
- valid rises in the same cycle as start and falls in the cycle after the press pulse that leaves READY.
- Holding btn high produces exactly one event. The next event needs db to fall first, which needs release stable for DEBOUNCE_CYCLES.
- Minimum spacing between events: about 2*DEBOUNCE_CYCLES cycles. Back-to-back press pulses are impossible by construction.

## Structure
- Shared package aluop_pkg holds:
  - the state enum ENTER_A/ENTER_B/ENTER_OP/READY with the encodings above;
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_MOV=6, OP_INC=7, OP_DEC=8;
  - OP_LAST=8, used for bad_op.
- One sub-module, button_debounce: synchronizer, counter, rising-edge pulse.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst, raw, level, rise.
  - It is reused for future buttons.
- The FSM and capture registers live in aluop_loader.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then hold btn=0 for 20 cycles -> all outputs 0, stage=00, no start.
- Three clean presses with sw=8'h22, then 8'h11, then 8'h00 -> opa=22, opb=11, opcode=0, valid=1, start for exactly 1 cycle, stage=11, bad_op=0.
- Bouncy btn (toggling every 1-3 cycles for 10 cycles, then stable high) -> exactly one press; stage advances by one.
- Enter opcode sw=8'hF9 -> opcode=9, bad_op=1, valid=1. Another press -> valid=0, bad_op=0, stage=00, opa/opb/opcode unchanged.
- Change sw to 8'h55 in the cycles between presses, but hold 8'h33 on the press cycle -> the captured value is 33.
- Assert rst while in ENTER_OP with a press mid-debounce -> the next cycle shows all reset values, and no press event follows once btn stays high.
